// File: rtl/pc_sequencer.sv
// KGP-RISC program-counter sequencer: fetch/decode/execute FSM that resolves branches and runs execute ops via an ex_start/ex_done handshake.
// Branch 4 cycles, execute 5+N; stalls in WAIT until i_ex_done; optional return stack when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_run,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic [31:0]     i_instr,
  output logic [2:0]      o_opcode,
  output logic [3:0]      o_fcode,
  output logic [PC_W-1:0] o_branch_addr,
  output logic [PC_W-1:0] o_pc,
  input  logic [PC_W-1:0] i_branch_PC,
  input  logic            i_PC_select,
  output logic            o_ex_start,
  input  logic            i_ex_done,
  input  logic            i_flag_we,
  input  logic [3:0]      i_flags_in,
  output logic            o_carryFlag,
  output logic            o_zeroFlag,
  output logic            o_overflowFlag,
  output logic            o_signFlag,
  output logic            o_halted,
  output logic            o_ras_err
);
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_HALT   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_UPDATE, S_HALT
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_inc, w_pc_nxt;
  logic [31:0]     r_ir;
  logic [3:0]      r_flags;
  logic            w_is_branch;
  logic            w_unused_ir;

  assign w_is_branch = (r_ir[31:29] == OP_BRANCH);
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_unused_ir = ^r_ir[24:PC_W];

  always_comb begin
    w_state_nxt = r_state;
    o_ex_start  = 1'b0;
    case (r_state)
      S_IDLE:   if (i_run) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (r_ir[31:29] == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else if (w_is_branch) begin
          w_state_nxt = S_UPDATE;
        end else begin
          o_ex_start  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:   if (i_ex_done) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = i_run ? S_FETCH : S_IDLE;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

`ifdef PC_SEQ_RAS_EN
  localparam int SP_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [SP_W-1:0] r_sp, w_sp_dec;
  logic [SP_W:0]   r_cnt;
  logic            r_ras_err;
  logic            w_call, w_ret, w_empty, w_full;

  assign w_call   = (r_state == S_UPDATE) && w_is_branch && (r_ir[28:25] == 4'b1001);
  assign w_ret    = (r_state == S_UPDATE) && w_is_branch && (r_ir[28:25] == 4'b1010);
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == (SP_W+1)'(RAS_DEPTH));
  assign w_sp_dec = r_sp - SP_W'(1);

  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (w_ret) begin
      w_pc_nxt = w_empty ? i_branch_PC : r_ras[w_sp_dec];
    end else if (w_is_branch && i_PC_select) begin
      w_pc_nxt = i_branch_PC;
    end
  end

  // Circular stack: a push when full overwrites the oldest entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp      <= '0;
      r_cnt     <= '0;
      r_ras_err <= 1'b0;
    end else if (w_call) begin
      r_ras[r_sp] <= w_pc_inc;
      r_sp        <= r_sp + SP_W'(1);
      if (w_full) r_ras_err <= 1'b1;
      else        r_cnt     <= r_cnt + (SP_W+1)'(1);
    end else if (w_ret) begin
      if (w_empty) begin
        r_ras_err <= 1'b1;
      end else begin
        r_sp  <= w_sp_dec;
        r_cnt <= r_cnt - (SP_W+1)'(1);
      end
    end
  end

  assign o_ras_err = r_ras_err;
`else
  localparam int unused_ras_depth = RAS_DEPTH;

  assign w_pc_nxt  = (w_is_branch && i_PC_select) ? i_branch_PC : w_pc_inc;
  assign o_ras_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE:   if (i_run) r_pc <= '0;
        S_DECODE: r_ir <= i_instr;
        S_WAIT:   if (i_ex_done && i_flag_we) r_flags <= i_flags_in;
        S_UPDATE: r_pc <= w_pc_nxt;
        default:  ;
      endcase
    end
  end

  assign o_imem_addr    = r_pc;
  assign o_pc           = r_pc;
  assign o_opcode       = r_ir[31:29];
  assign o_fcode        = r_ir[28:25];
  assign o_branch_addr  = r_ir[PC_W-1:0];
  assign o_carryFlag    = r_flags[3];
  assign o_zeroFlag     = r_flags[2];
  assign o_overflowFlag = r_flags[1];
  assign o_signFlag     = r_flags[0];
  assign o_halted       = (r_state == S_HALT);
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: branch vector table, directed handshake/halt/reset sequences,
// and a random program checked against an instruction-level model of the sequencer.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, run;
  logic [7:0]  imem_addr, branch_addr, pc, branch_PC;
  logic [31:0] instr;
  logic [2:0]  opcode;
  logic [3:0]  fcode, flags_in;
  logic        PC_select, ex_start, ex_done, flag_we;
  logic        cf, zf, vf, sf, halted, ras_err;

  logic [31:0] imem [256];
  logic        use_bu, tb_sel;
  logic [7:0]  tb_bpc;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory and a cycle counter.
  always @(posedge clk) begin
    instr <= imem[imem_addr];
    cyc   <= cyc + 1;
  end

  // Branch unit stand-in: either bench-forced, or "take IR address when fcode[0]".
  assign PC_select = use_bu ? fcode[0] : tb_sel;
  assign branch_PC = use_bu ? branch_addr : tb_bpc;

  pc_sequencer #(.PC_W(8), .RAS_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run),
    .o_imem_addr(imem_addr), .i_instr(instr),
    .o_opcode(opcode), .o_fcode(fcode), .o_branch_addr(branch_addr), .o_pc(pc),
    .i_branch_PC(branch_PC), .i_PC_select(PC_select),
    .o_ex_start(ex_start), .i_ex_done(ex_done), .i_flag_we(flag_we), .i_flags_in(flags_in),
    .o_carryFlag(cf), .o_zeroFlag(zf), .o_overflowFlag(vf), .o_signFlag(sf),
    .o_halted(halted), .o_ras_err(ras_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] fc, input logic [7:0] a);
    return {op, fc, 17'd0, a};
  endfunction

  // Called at the negedge of FETCH for address cur; leaves at the next FETCH negedge.
  task automatic br(input logic [7:0] cur, input logic [3:0] fc, input logic [7:0] a,
                    input logic sel, input logic [7:0] bpc, input logic [7:0] nxt, input string nm);
    imem[cur] = mk(3'b011, fc, a);
    tb_sel = sel;
    tb_bpc = bpc;
    repeat (4) @(negedge clk);
    chk(nm, pc, nxt);
  endtask

  typedef struct {
    logic [7:0] at;
    logic [3:0] fc;
    logic [7:0] addr;
    logic       sel;
    logic [7:0] bpc;
    logic [7:0] nxt;
  } bvec_t;
  bvec_t tbl [5];

  logic [2:0] eops [6];
  logic [7:0] m_pc;
  logic [3:0] m_flags, fl;
  int         b, exp_gap, t_prev, cnt, d, pulses, t;
  logic       seen, fw, spur;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'd0,   4'h0, 8'd200, 1'b0, 8'd201, 8'd1};
    tbl[1] = '{8'd1,   4'h3, 8'd5,   1'b1, 8'd5,   8'd5};
    tbl[2] = '{8'd5,   4'h0, 8'd35,  1'b1, 8'd35,  8'd35};
    tbl[3] = '{8'd35,  4'h6, 8'd12,  1'b1, 8'd255, 8'd255};
    tbl[4] = '{8'd255, 4'h0, 8'd35,  1'b0, 8'd35,  8'd0};
    eops[0] = 3'd0; eops[1] = 3'd1; eops[2] = 3'd2;
    eops[3] = 3'd4; eops[4] = 3'd5; eops[5] = 3'd6;
    for (int a = 0; a < 256; a++) imem[a] = 32'h0;

    rst = 1'b1; run = 1'b0; ex_done = 1'b0; flag_we = 1'b0; flags_in = 4'h0;
    use_bu = 1'b0; tb_sel = 1'b0; tb_bpc = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_ir", {opcode, fcode, branch_addr}, 0);
    chk("rst_flags", {cf, zf, vf, sf}, 0);
    chk("rst_ctl", {ex_start, halted, ras_err}, 0);

    rst = 1'b0; run = 1'b1;
    @(negedge clk);
    // Branch vector table: each entry is fetched at the previous entry's next PC.
    for (int i = 0; i < 5; i++) begin
      chk("tbl_fetch_addr", imem_addr, tbl[i].at);
      imem[tbl[i].at] = mk(3'b011, tbl[i].fc, tbl[i].addr);
      tb_sel = tbl[i].sel;
      tb_bpc = tbl[i].bpc;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (ex_start) seen = 1'b1;
        if (c == 1) chk("tbl_ir_addr", branch_addr, tbl[i].addr);
        if (c == 2) chk("tbl_pc_hold", pc, tbl[i].at);
      end
      chk("tbl_no_ex_start", seen, 0);
      chk("tbl_next_pc", pc, tbl[i].nxt);
    end

    // Execute handshake: ex_done three cycles after ex_start.
    imem[0] = mk(3'b000, 4'h5, 8'd9);
    pulses = 0;
    @(negedge clk); pulses += int'(ex_start);
    @(negedge clk); pulses += int'(ex_start);
    chk("exec_start_in_exec", ex_start, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      pulses += int'(ex_start);
      if (c == 2) chk("exec_flags_before", {cf, zf, vf, sf}, 0);
      if (c == 3) begin ex_done = 1'b1; flag_we = 1'b1; flags_in = 4'b0100; end
    end
    @(negedge clk);
    ex_done = 1'b0; flag_we = 1'b0; flags_in = 4'h0;
    pulses += int'(ex_start);
    chk("exec_pc_hold", pc, 0);
    chk("exec_flags", {cf, zf, vf, sf}, 4'b0100);
    @(negedge clk);
    chk("exec_next_fetch", imem_addr, 1);
    chk("exec_one_pulse", pulses, 1);

    // Halt at PC 1.
    imem[1] = mk(3'b111, 4'h0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("halt_not_yet", halted, 0);
    @(negedge clk);
    chk("halt_rises", halted, 1);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (ex_start) seen = 1'b1; end
    chk("halt_pc_frozen", pc, 1);
    chk("halt_stays", {halted, seen}, 2'b10);

    rst = 1'b1;
    @(negedge clk);
    chk("rst_from_halt", {halted, pc, cf, zf, vf, sf}, 0);

    // Reset during WAIT; a late ex_done must be ignored.
    rst = 1'b0; run = 1'b1;
    @(negedge clk);
    imem[0] = mk(3'b101, 4'h2, 8'd3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    chk("rstw_pc", pc, 0);
    chk("rstw_opcode", opcode, 0);
    rst = 1'b0; ex_done = 1'b1; flag_we = 1'b1; flags_in = 4'b1111;
    @(negedge clk);
    ex_done = 1'b0; flag_we = 1'b0; flags_in = 4'h0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (ex_start) seen = 1'b1; end
    chk("rstw_late_done", {seen, cf, zf, vf, sf, pc}, 0);
    run = 1'b1;
    @(negedge clk);
    chk("rstw_refetch", imem_addr, 0);

    // Random program: branches at a%3==2 never target another branch slot.
    use_bu = 1'b1;
    for (int a = 0; a < 256; a++) begin
      if (a % 3 == 2) begin
        t = $urandom_range(0, 255);
        if (t % 3 == 2) t = t - 1;
        imem[a] = mk(3'b011, 4'($urandom_range(0, 7)), 8'(t));
      end else begin
        imem[a] = {eops[$urandom_range(0, 5)], 29'($urandom)};
      end
    end
    m_pc = 8'd0; m_flags = 4'h0; b = 0;
    while (imem[m_pc][31:29] == 3'b011) begin
      b++;
      m_pc = imem[m_pc][25] ? imem[m_pc][7:0] : m_pc + 8'd1;
    end
    exp_gap = 4 * b + 2;
    t_prev = cyc;
    for (int k = 0; k < 40; k++) begin
      cnt = 0;
      while (!ex_start && cnt < 200) begin @(negedge clk); cnt++; end
      if (!ex_start) begin
        chk("rnd_ex_start_timeout", 0, 1);
        break;
      end
      chk("rnd_gap", cyc - t_prev, exp_gap);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_opcode", opcode, imem[m_pc][31:29]);
      chk("rnd_flags", {cf, zf, vf, sf}, m_flags);
      t_prev = cyc;
      d = $urandom_range(1, 4);
      fw = 1'($urandom);
      fl = 4'($urandom);
      spur = 1'($urandom);
      if (spur) begin ex_done = 1'b1; flag_we = 1'b1; flags_in = ~fl; end
      @(negedge clk);
      ex_done = 1'b0; flag_we = 1'b0;
      repeat (d - 1) @(negedge clk);
      ex_done = 1'b1; flag_we = fw; flags_in = fl;
      @(negedge clk);
      ex_done = 1'b0; flag_we = 1'b0; flags_in = 4'($urandom);
      if (fw) m_flags = fl;
      m_pc = m_pc + 8'd1;
      b = 0;
      while (imem[m_pc][31:29] == 3'b011) begin
        b++;
        m_pc = imem[m_pc][25] ? imem[m_pc][7:0] : m_pc + 8'd1;
      end
      exp_gap = d + 4 + 4 * b;
    end

    use_bu = 1'b0; rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    @(negedge clk);
`ifdef PC_SEQ_RAS_EN
    br(8'd0,  4'h0, 8'd10, 1'b1, 8'd10, 8'd10, "ras_jmp10");
    br(8'd10, 4'h9, 8'd40, 1'b1, 8'd40, 8'd40, "ras_call");
    br(8'd40, 4'hA, 8'd99, 1'b0, 8'd99, 8'd11, "ras_ret");
    chk("ras_err_clean", ras_err, 0);
    br(8'd11, 4'h9, 8'd20, 1'b1, 8'd20, 8'd20, "ras_call1");
    br(8'd20, 4'h9, 8'd30, 1'b1, 8'd30, 8'd30, "ras_call2");
    br(8'd30, 4'h9, 8'd40, 1'b1, 8'd40, 8'd40, "ras_call3");
    br(8'd40, 4'h9, 8'd50, 1'b1, 8'd50, 8'd50, "ras_call4");
    chk("ras_err_full_ok", ras_err, 0);
    br(8'd50, 4'h9, 8'd60, 1'b1, 8'd60, 8'd60, "ras_call5");
    chk("ras_err_overflow", ras_err, 1);
    br(8'd60, 4'hA, 8'd0,  1'b0, 8'd0,  8'd51, "ras_pop1");
    br(8'd51, 4'hA, 8'd0,  1'b0, 8'd0,  8'd41, "ras_pop2");
    br(8'd41, 4'hA, 8'd0,  1'b0, 8'd0,  8'd31, "ras_pop3");
    br(8'd31, 4'hA, 8'd0,  1'b0, 8'd0,  8'd21, "ras_pop4");
    br(8'd21, 4'hA, 8'd77, 1'b1, 8'd77, 8'd77, "ras_pop_empty");
    chk("ras_err_sticky", ras_err, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("ras_err_rst", ras_err, 0);
    rst = 1'b0;
    @(negedge clk);
    br(8'd0, 4'hA, 8'd88, 1'b1, 8'd88, 8'd88, "ras_ret_empty");
    chk("ras_err_underflow", ras_err, 1);
`else
    br(8'd0,  4'hA, 8'd99, 1'b1, 8'd66, 8'd66, "noras_ret");
    br(8'd66, 4'h9, 8'd40, 1'b0, 8'd40, 8'd67, "noras_call");
    chk("noras_err", ras_err, 0);
`endif
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle control FSM that owns the program counter and sequences the instruction-fetch / branch-unit datapath of the KGP-RISC core. It fetches each instruction from synchronous instruction memory, hands non-branch instructions to the execute datapath with a start/done handshake, latches the condition flags, and resolves branch-class instructions using the branch unit's `branch_PC` / `PC_select` outputs. An optional hardware return-address stack services call/ret.

## Interface
Parameters:
- `PC_W`, 8, program-counter / instruction-address width
- `RAS_DEPTH`, 4, return-stack entries; power of two; used only with `RAS_EN`

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  level; leave IDLE and start fetching at PC 0
- `imem_addr`  out  PC_W  instruction-memory address (= PC)
- `instr`  in  32  instruction word; valid the cycle after `imem_addr` is presented
- `opcode`  out  3  `instr[31:29]` of the latched instruction register (IR)
- `fcode`  out  4  `IR[28:25]`
- `branch_addr`  out  PC_W  `IR[PC_W-1:0]`
- `pc`  out  PC_W  current PC, fed to the branch unit
- `branch_PC`  in  PC_W  target from branch unit
- `PC_select`  in  1  branch unit: 1 = take `branch_PC`
- `ex_start`  out  1  one-cycle pulse: execute IR (non-branch op)
- `ex_done`  in  1  execute datapath finished
- `flag_we`  in  1  sampled with `ex_done`; load flags
- `flags_in`  in  4  {carry, zero, overflow, sign} from ALU
- `carryFlag`, `zeroFlag`, `overflowFlag`, `signFlag`  out  1 each  registered flags
- `halted`  out  1  high in HALT state
- `ras_err`  out  1  sticky; return-stack overflow/underflow seen (0 without `RAS_EN`)

## Operation
- Decode: `opcode` 3'b011 = branch class; 3'b111 = halt; all others = execute class.
- States: IDLE, FETCH, DECODE, EXEC, WAIT, UPDATE, HALT.
- IDLE: PC = 0; go FETCH when `run` = 1.
- FETCH: `imem_addr` = PC; go DECODE.
- DECODE: IR <= `instr`; go EXEC.
- EXEC: halt -> HALT. Branch -> UPDATE (branch unit is combinational off IR, PC, flags). Execute -> pulse `ex_start`, go WAIT.
- WAIT: hold until `ex_done`; on `ex_done`, if `flag_we` load flags from `flags_in`; go UPDATE. `ex_done` sampled in EXEC's own cycle is ignored.
- UPDATE: next PC = `branch_PC` if branch class and `PC_select`, else PC + 1 (mod 2^PC_W, 255 -> 0). Go FETCH if `run`, else IDLE (PC kept).
- HALT: terminal; only `rst` exits. `run` ignored.
- Flags change only in WAIT on `ex_done & flag_we`; branches never modify flags.
- `rst` in any state, including WAIT mid-handshake: all state cleared next edge; pending `ex_done` afterwards ignored.

## Timing
- Reset values: state IDLE, PC 0, IR 0 (so `opcode`, `fcode`, `branch_addr` 0), all flags 0, `ex_start` 0, `halted` 0, `ras_err` 0, return-stack empty.
- Branch instruction: 4 cycles FETCH..UPDATE; new PC visible on `imem_addr` in the next FETCH.
- Execute instruction: 5 + N cycles, N = cycles from `ex_start` to `ex_done` (N ≥ 0 counted after WAIT entry).
- `ex_start` high exactly one cycle per execute instruction.
- `halted` rises the cycle after EXEC sees opcode 3'b111.

## Configuration
- `PC_SEQ_RAS_EN` defined: `RAS_DEPTH`-entry return stack. Branch `fcode` 4'b1001 (call) pushes PC + 1 in UPDATE; `fcode` 4'b1010 (ret) pops and uses the popped value as next PC, ignoring `branch_PC`. Push when full overwrites the oldest entry (pointer wraps) and sets `ras_err`. Pop when empty uses `branch_PC` and sets `ras_err`.
- Not defined: no stack; call/ret follow `branch_PC` / `PC_select` like other branches; `ras_err` tied 0.

## Test plan
- Reset/run: `rst` for 2 cycles, then `run` = 1 -> all outputs at reset values during reset; `imem_addr` 0 on the first FETCH, 1 on the next.
- Taken branch: IR = opcode 011, fcode 0000, addr 35 at PC 5, `PC_select` = 1, `branch_PC` = 35 -> next FETCH `imem_addr` = 35, 4 cycles total.
- Not taken + wrap: PC 255, opcode 011, `PC_select` = 0 -> next PC 0.
- Execute handshake: opcode 000, `ex_done` 3 cycles after `ex_start` with `flag_we` = 1, `flags_in` = 4'b0100 -> single `ex_start` pulse, `zeroFlag` = 1, others 0, PC + 1.
- Halt/reset mid-op: opcode 111 -> `halted` = 1, PC frozen despite `run`; `rst` asserted during WAIT -> IDLE, PC 0, later `ex_done` ignored.
- `PC_SEQ_RAS_EN`: call at PC 10 to 40, ret at 40 -> PC 11; five calls with `RAS_DEPTH` 4 -> `ras_err` = 1; ret on empty stack -> uses `branch_PC`, `ras_err` = 1.
